// File: rtl/phase_detector_if.sv
// Signal bundle between the phase detector and the loop filter side.
// The detector uses the slave modport; whatever drives the clock inputs uses master.
interface phase_detector_if #(
  parameter int unsigned WIDTH = 20
);
  logic             reference_i;
  logic             generated_i;
  logic [WIDTH-1:0] pd_clock_cycles_o;

  modport master (
    output reference_i,
    output generated_i,
    input  pd_clock_cycles_o
  );

  modport slave (
    input  reference_i,
    input  generated_i,
    output pd_clock_cycles_o
  );
endinterface

// File: rtl/phase_detector.sv
// Time-to-digital phase detector: signed cycle distance between a reference rising edge
// and the nearest generated-clock rising edge, held until the next measurement completes.
module phase_detector #(
  parameter int unsigned WIDTH = 20
) (
  input  logic            fpga_clk_i,
  input  logic            reset_i,
  phase_detector_if.slave pd_if
);

  localparam logic [WIDTH-1:0] CntMax = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {StIdle, StGenLead, StRefLead} state_e;

  // [0],[1] synchronise, [2] delays [1] for rising-edge detection
  logic [2:0] ref_sync_q, gen_sync_q;
  logic       ref_rise, gen_rise;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] cnt_inc;

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      ref_sync_q <= '0;
      gen_sync_q <= '0;
    end else begin
      ref_sync_q <= {ref_sync_q[1:0], pd_if.reference_i};
      gen_sync_q <= {gen_sync_q[1:0], pd_if.generated_i};
    end
  end

  assign ref_rise = ref_sync_q[1] & ~ref_sync_q[2];
  assign gen_rise = gen_sync_q[1] & ~gen_sync_q[2];

  // Saturating increment doubles as the completed-measurement magnitude (counter + 1)
  assign cnt_inc = (cnt_q == CntMax) ? CntMax : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      StIdle: begin
        if (gen_rise && ref_rise) begin
          out_d = '0;
        end else if (gen_rise) begin
          cnt_d   = '0;
          state_d = StGenLead;
        end else if (ref_rise) begin
          cnt_d   = '0;
          state_d = StRefLead;
        end
      end
      StGenLead: begin
        if (ref_rise) begin
          out_d   = cnt_inc;
          state_d = StIdle;
        end else if (gen_rise) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRefLead: begin
        if (gen_rise) begin
          out_d   = -cnt_inc;
          state_d = StIdle;
        end else if (ref_rise) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign pd_if.pd_clock_cycles_o = out_q;

endmodule

// File: tb/tb_phase_detector.sv
// Bench for phase_detector: WIDTH=20 and WIDTH=8 instances share stimulus and are checked
// every sampled cycle against an edge-level reference model, plus fixed scenario values.
module tb_phase_detector;

  localparam int Max20 = 524287;
  localparam int Max8  = 127;

  logic clk;
  logic rst;

  phase_detector_if #(.WIDTH(20)) if20 ();
  phase_detector_if #(.WIDTH(8))  if8 ();

  phase_detector #(.WIDTH(20)) dut20 (
    .fpga_clk_i (clk),
    .reset_i    (rst),
    .pd_if      (if20)
  );

  phase_detector #(.WIDTH(8)) dut8 (
    .fpga_clk_i (clk),
    .reset_i    (rst),
    .pd_if      (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int v20;
    int v8;
  } pend_t;

  pend_t pend[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    exp20 = 0;
  int    exp8 = 0;
  int    m_state = 0;  // 0 waiting, 1 generated leading, 2 reference leading
  int    m_start = 0;
  bit    prev_r = 1'b0;
  bit    prev_g = 1'b0;

  function automatic int sat(input int d, input int mx);
    return (d > mx) ? mx : d;
  endfunction

  // One sampling cycle: settle expectation for outputs seen now, then drive and model.
  task automatic step(input bit r, input bit g, input bit rs);
    bit rr, gr;
    int d;
    @(negedge clk);
    while (pend.size() > 0 && pend[0].due <= cyc) begin
      exp20 = pend[0].v20;
      exp8  = pend[0].v8;
      pend.delete(0);
    end
    rst = rs;
    if20.reference_i = r;
    if20.generated_i = g;
    if8.reference_i  = r;
    if8.generated_i  = g;
    if (rs) begin
      pend.delete();
      pend.push_back('{cyc + 1, 0, 0});
      m_state = 0;
      prev_r  = 1'b0;
      prev_g  = 1'b0;
    end else begin
      rr = r && !prev_r;
      gr = g && !prev_g;
      prev_r = r;
      prev_g = g;
      d = cyc - m_start;
      case (m_state)
        0: begin
          if (rr && gr) pend.push_back('{cyc + 3, 0, 0});
          else if (gr) begin m_state = 1; m_start = cyc; end
          else if (rr) begin m_state = 2; m_start = cyc; end
        end
        1: begin
          if (rr) begin
            pend.push_back('{cyc + 3, sat(d, Max20), sat(d, Max8)});
            m_state = 0;
          end else if (gr) m_start = cyc;
        end
        default: begin
          if (gr) begin
            pend.push_back('{cyc + 3, -sat(d, Max20), -sat(d, Max8)});
            m_state = 0;
          end else if (rr) m_start = cyc;
        end
      endcase
    end
    cyc++;
  endtask

  task automatic test_reset;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 1'b0);
      tests++;
      if (if20.pd_clock_cycles_o !== 20'h0 || if8.pd_clock_cycles_o !== 8'h0) begin
        fails++;
        $display("FAIL reset k=%0d: got %h/%h want 0/0", k, if20.pd_clock_cycles_o,
                 if8.pd_clock_cycles_o);
      end
    end
  endtask

  task automatic test_gen_lead;
    for (int k = 0; k < 40; k++) begin
      step(k >= 12 && k < 32, k >= 2 && k < 22, 1'b0);
      tests++;
      if ($signed(if20.pd_clock_cycles_o) !== exp20 || $signed(if8.pd_clock_cycles_o) !== exp8) begin
        fails++;
        $display("FAIL gen_lead k=%0d: got %0d/%0d want %0d/%0d", k,
                 $signed(if20.pd_clock_cycles_o), $signed(if8.pd_clock_cycles_o), exp20, exp8);
      end
      if (k == 16 || k == 39) begin
        tests++;
        if (if20.pd_clock_cycles_o !== 20'h0000A || if8.pd_clock_cycles_o !== 8'h0A) begin
          fails++;
          $display("FAIL gen_lead_value k=%0d: got %h/%h want 0000a/0a", k,
                   if20.pd_clock_cycles_o, if8.pd_clock_cycles_o);
        end
      end
    end
  endtask

  task automatic test_ref_lead;
    for (int k = 0; k < 40; k++) begin
      step(k >= 2 && k < 22, k >= 12 && k < 32, 1'b0);
      tests++;
      if ($signed(if20.pd_clock_cycles_o) !== exp20 || $signed(if8.pd_clock_cycles_o) !== exp8) begin
        fails++;
        $display("FAIL ref_lead k=%0d: got %0d/%0d want %0d/%0d", k,
                 $signed(if20.pd_clock_cycles_o), $signed(if8.pd_clock_cycles_o), exp20, exp8);
      end
    end
    tests++;
    if (if20.pd_clock_cycles_o !== 20'hFFFF6 || if8.pd_clock_cycles_o !== 8'hF6) begin
      fails++;
      $display("FAIL ref_lead_value: got %h/%h want ffff6/f6", if20.pd_clock_cycles_o,
               if8.pd_clock_cycles_o);
    end
  endtask

  task automatic test_second_period;
    bit r, g;
    for (int k = 0; k < 141; k++) begin
      g = (k < 40) || (k >= 60 && k < 100);
      r = (k >= 10 && k < 50) || (k >= 90 && k < 130);
      step(r, g, 1'b0);
      tests++;
      if ($signed(if20.pd_clock_cycles_o) !== exp20 || $signed(if8.pd_clock_cycles_o) !== exp8) begin
        fails++;
        $display("FAIL second_period k=%0d: got %0d/%0d want %0d/%0d", k,
                 $signed(if20.pd_clock_cycles_o), $signed(if8.pd_clock_cycles_o), exp20, exp8);
      end
      if (k == 92 && if20.pd_clock_cycles_o !== 20'd10) begin
        fails++;
        $display("FAIL second_period_hold: got %0d want 10", if20.pd_clock_cycles_o);
      end
      if (k == 94 || k == 140) begin
        tests++;
        if (if20.pd_clock_cycles_o !== 20'd30 || if8.pd_clock_cycles_o !== 8'd30) begin
          fails++;
          $display("FAIL second_period_value k=%0d: got %0d/%0d want 30/30", k,
                   if20.pd_clock_cycles_o, if8.pd_clock_cycles_o);
        end
      end
      if (k == 92) tests++;
    end
  endtask

  // Runs a scripted pattern and checks both the model and a fixed final result.
  task automatic test_pattern(input string name, input int g0, input int g1, input int g2,
                              input int g3, input int r0, input int r1, input int len,
                              input int want);
    bit r, g;
    for (int k = 0; k < len; k++) begin
      g = (k >= g0 && k < g1) || (k >= g2 && k < g3);
      r = (k >= r0 && k < r1);
      step(r, g, 1'b0);
      tests++;
      if ($signed(if20.pd_clock_cycles_o) !== exp20 || $signed(if8.pd_clock_cycles_o) !== exp8) begin
        fails++;
        $display("FAIL %s k=%0d: got %0d/%0d want %0d/%0d", name, k,
                 $signed(if20.pd_clock_cycles_o), $signed(if8.pd_clock_cycles_o), exp20, exp8);
      end
    end
    tests++;
    if ($signed(if20.pd_clock_cycles_o) !== want || $signed(if8.pd_clock_cycles_o) !== want) begin
      fails++;
      $display("FAIL %s_value: got %0d/%0d want %0d", name, $signed(if20.pd_clock_cycles_o),
               $signed(if8.pd_clock_cycles_o), want);
    end
  endtask

  task automatic test_saturation;
    bit r, g, rs;
    for (int k = 0; k < 330; k++) begin
      g  = (k >= 2 && k < 230) || (k >= 250 && k < 260) || (k >= 290 && k < 320);
      r  = (k >= 202 && k < 230) || (k >= 300 && k < 320);
      rs = (k == 275 || k == 276);
      step(r, g, rs);
      tests++;
      if (k > 0 &&
          ($signed(if20.pd_clock_cycles_o) !== exp20 || $signed(if8.pd_clock_cycles_o) !== exp8)) begin
        fails++;
        $display("FAIL saturation k=%0d: got %0d/%0d want %0d/%0d", k,
                 $signed(if20.pd_clock_cycles_o), $signed(if8.pd_clock_cycles_o), exp20, exp8);
      end
      if (k == 240) begin
        tests++;
        if (if8.pd_clock_cycles_o !== 8'h7F || if20.pd_clock_cycles_o !== 20'd200) begin
          fails++;
          $display("FAIL saturation_value: got %h/%0d want 7f/200", if8.pd_clock_cycles_o,
                   if20.pd_clock_cycles_o);
        end
      end
      if (k == 279) begin
        tests++;
        if (if8.pd_clock_cycles_o !== 8'h0 || if20.pd_clock_cycles_o !== 20'h0) begin
          fails++;
          $display("FAIL reset_mid_measure: got %h/%h want 0/0", if8.pd_clock_cycles_o,
                   if20.pd_clock_cycles_o);
        end
      end
      if (k == 329) begin
        tests++;
        if (if8.pd_clock_cycles_o !== 8'd10 || if20.pd_clock_cycles_o !== 20'd10) begin
          fails++;
          $display("FAIL after_reset_value: got %0d/%0d want 10/10", if8.pd_clock_cycles_o,
                   if20.pd_clock_cycles_o);
        end
      end
    end
  endtask

  task automatic test_random;
    bit r, g, rs;
    int rl, gl;
    r  = 1'b0;
    g  = 1'b0;
    rl = $urandom_range(2, 40);
    gl = $urandom_range(2, 40);
    for (int k = 0; k < 4000; k++) begin
      rl--;
      gl--;
      if (rl == 0) begin
        r  = !r;
        rl = ($urandom_range(0, 9) == 0) ? $urandom_range(100, 300) : $urandom_range(2, 40);
      end
      if (gl == 0) begin
        g  = !g;
        gl = ($urandom_range(0, 9) == 0) ? $urandom_range(100, 300) : $urandom_range(2, 40);
      end
      rs = ($urandom_range(0, 499) == 0);
      step(r, g, rs);
      tests++;
      if ($signed(if20.pd_clock_cycles_o) !== exp20 || $signed(if8.pd_clock_cycles_o) !== exp8) begin
        fails++;
        $display("FAIL random k=%0d: got %0d/%0d want %0d/%0d", k,
                 $signed(if20.pd_clock_cycles_o), $signed(if8.pd_clock_cycles_o), exp20, exp8);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    if20.reference_i = 1'b0;
    if20.generated_i = 1'b0;
    if8.reference_i  = 1'b0;
    if8.generated_i  = 1'b0;
    test_reset();
    test_gen_lead();
    test_ref_lead();
    test_second_period();
    test_pattern("simultaneous_idle", 2, 8, 0, 0, 2, 8, 16, 0);
    test_pattern("simultaneous_counting", 2, 5, 9, 14, 9, 14, 24, 7);
    test_pattern("restart", 2, 5, 8, 14, 12, 18, 26, 4);
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
